// File: rtl/sm83_pkg.sv
// -----------------------------------------------------------------------------
// sm83_pkg
//   Shared types and constants for the SM83 interrupt dispatch logic.
//   - int_state_t : dispatch sequencer states
//   - int_src_t   : interrupt source index (3 bits, lowest index wins)
//   - INT_VEC_BASE: vector address of source 0; source n is at base + 8*n
//   - SRC_*       : source index constants (VBLANK .. JOYPAD)
// -----------------------------------------------------------------------------
package sm83_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT0   = 3'd1,
        ST_WAIT1   = 3'd2,
        ST_PUSH_HI = 3'd3,
        ST_PUSH_LO = 3'd4,
        ST_JUMP    = 3'd5
    } int_state_t;

    typedef logic [2:0] int_src_t;

    localparam logic [15:0] INT_VEC_BASE = 16'h0040;
    localparam int          INT_NUM_SRC  = 5;

    localparam int_src_t SRC_VBLANK = 3'd0;
    localparam int_src_t SRC_STAT   = 3'd1;
    localparam int_src_t SRC_TIMER  = 3'd2;
    localparam int_src_t SRC_SERIAL = 3'd3;
    localparam int_src_t SRC_JOYPAD = 3'd4;

    // Vector address for a source: base + 8*idx, modulo 2^16.
    function automatic logic [15:0] int_vector(input logic [15:0] base,
                                               input int_src_t    idx);
        return base + {10'd0, idx, 3'b000};
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// -----------------------------------------------------------------------------
// int_prio_enc
//   Combinational lowest-set-bit encoder used to pick the interrupt source
//   to service. Bit 0 has the highest priority.
//
//   Ports:
//     req   in  W   request vector (ie & if_flags)
//     valid out 1   at least one request bit set
//     idx   out 3   index of the lowest set bit (0 when valid is low)
// -----------------------------------------------------------------------------
module int_prio_enc
    import sm83_pkg::*;
#(
    parameter int W = INT_NUM_SRC
) (
    input  logic [W-1:0] req,
    output logic         valid,
    output int_src_t     idx
);

    // Scan from the top down so the last hit is the lowest set bit.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = int_src_t'(i);
            end
        end
    end

endmodule

// File: rtl/int_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// int_dispatch_ctrl
//   SM83 interrupt dispatch sequencer. At an instruction boundary with IME set
//   and a pending, enabled source, it clears IME, pushes PC (high byte first)
//   onto the stack through the SP and memory write ports, then loads PC with
//   the vector of the lowest-numbered pending source and clears its IF bit.
//   The SP/PC/memory write paths belong to this block only while busy is high.
//
//   Sequence: IDLE -> WAIT0 -> WAIT1 -> PUSH_HI -> PUSH_LO -> JUMP -> IDLE
//   (PUSH_HI / PUSH_LO hold until mem_ack).
//
//   Optional build macro:
//     INT_IE_PUSH_CANCEL_EN - re-evaluate the source in the first PUSH_LO
//       cycle (models the PC-high push overwriting IE at 0xFFFF). If nothing
//       is pending then, JUMP writes PC=0x0000 and clears no IF bit.
//
//   Ports:
//     clk, rst            clock (one M-cycle step), synchronous active-high reset
//     boundary            core is at an instruction boundary
//     ime, ie, if_flags   master enable, IE register, pending IF flags
//     pc, sp              current PC / SP from the register file
//     irq_pending         ime & |(ie[4:0] & if_flags), combinational
//     busy                dispatch in progress
//     ime_clr             one-cycle IME clear pulse
//     if_clr              one-hot IF clear pulse for the serviced source
//     wen_sp, w_sp        SP write strobe / data
//     wen_pc, w_pc        PC write strobe / data
//     mem_req, mem_addr,  memory write request, held stable until mem_ack
//     mem_wdata
//     mem_ack             write accepted (may be in the same cycle as mem_req)
// -----------------------------------------------------------------------------
module int_dispatch_ctrl
    import sm83_pkg::*;
#(
    parameter logic [15:0] VEC_BASE = INT_VEC_BASE,
    parameter int          NUM_SRC  = INT_NUM_SRC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               boundary,
    input  logic               ime,
    input  logic [7:0]         ie,
    input  logic [NUM_SRC-1:0] if_flags,
    input  logic [15:0]        pc,
    input  logic [15:0]        sp,
    output logic               irq_pending,
    output logic               busy,
    output logic               ime_clr,
    output logic [NUM_SRC-1:0] if_clr,
    output logic               wen_sp,
    output logic [15:0]        w_sp,
    output logic               wen_pc,
    output logic [15:0]        w_pc,
    output logic               mem_req,
    output logic [15:0]        mem_addr,
    output logic [7:0]         mem_wdata,
    input  logic               mem_ack
);

    function automatic logic [15:0] vec_addr(input int_src_t idx);
        return int_vector(VEC_BASE, idx);
    endfunction

    function automatic logic [NUM_SRC-1:0] src_onehot(input int_src_t idx);
        return {{(NUM_SRC-1){1'b0}}, 1'b1} << idx;
    endfunction

    int_state_t           state_q, state_d;
    int_src_t             idx_q, idx_d;
    logic                 busy_q, busy_d;
    logic                 ime_clr_q, ime_clr_d;
    logic [NUM_SRC-1:0]   if_clr_q, if_clr_d;
    logic                 wen_sp_q, wen_sp_d;
    logic [15:0]          w_sp_q, w_sp_d;
    logic                 wen_pc_q, wen_pc_d;
    logic [15:0]          w_pc_q, w_pc_d;
    logic                 mem_req_q, mem_req_d;
    logic [15:0]          mem_addr_q, mem_addr_d;
    logic [7:0]           mem_wdata_q, mem_wdata_d;

    logic [NUM_SRC-1:0]   pend;
    logic                 enc_valid;
    int_src_t             enc_idx;
    logic                 eff_valid;
    int_src_t             eff_idx;
    logic                 push_hi_ack;
    logic                 unused_ie_hi;

`ifdef INT_IE_PUSH_CANCEL_EN
    logic                 lo_first_q, lo_first_d;
    logic                 idx_vld_q, idx_vld_d;
`endif

    // Only the low NUM_SRC bits of IE name real sources.
    assign unused_ie_hi = ^(ie >> NUM_SRC);
    assign pend         = ie[NUM_SRC-1:0] & if_flags;

    // One encoder serves both the IDLE decision and the PUSH_LO re-check.
    int_prio_enc #(
        .W (NUM_SRC)
    ) u_prio_enc (
        .req   (pend),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    assign irq_pending = ime & enc_valid;

`ifdef INT_IE_PUSH_CANCEL_EN
    // In the first PUSH_LO cycle the live encoder result overrides the latch,
    // so an ack arriving in that same cycle already sees the re-evaluation.
    assign eff_valid = lo_first_q ? enc_valid : idx_vld_q;
    assign eff_idx   = lo_first_q ? enc_idx   : idx_q;
`else
    assign eff_valid = 1'b1;
    assign eff_idx   = idx_q;
`endif

    // The second SP decrement must coincide with the PC-high ack, which can
    // arrive in the same cycle as the request, so it bypasses the registers.
    assign push_hi_ack = (state_q == ST_PUSH_HI) && mem_ack;

    assign busy      = busy_q;
    assign ime_clr   = ime_clr_q;
    assign if_clr    = if_clr_q;
    assign wen_sp    = wen_sp_q | push_hi_ack;
    assign w_sp      = push_hi_ack ? (sp - 16'd1) : w_sp_q;
    assign wen_pc    = wen_pc_q;
    assign w_pc      = w_pc_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Next state and the output values to present during that next state.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ime_clr_d   = 1'b0;
        if_clr_d    = '0;
        wen_sp_d    = 1'b0;
        w_sp_d      = '0;
        wen_pc_d    = 1'b0;
        w_pc_d      = '0;
        mem_req_d   = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
`ifdef INT_IE_PUSH_CANCEL_EN
        lo_first_d  = 1'b0;
        idx_vld_d   = idx_vld_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (boundary && irq_pending) begin
                    state_d   = ST_WAIT0;
                    ime_clr_d = 1'b1;
                    idx_d     = enc_idx;
`ifdef INT_IE_PUSH_CANCEL_EN
                    idx_vld_d = 1'b1;
`endif
                end
            end

            ST_WAIT0: begin
                state_d  = ST_WAIT1;
                wen_sp_d = 1'b1;
                w_sp_d   = sp - 16'd1;
            end

            ST_WAIT1: begin
                // The SP written in WAIT1 is the address of the high-byte push.
                state_d     = ST_PUSH_HI;
                mem_req_d   = 1'b1;
                mem_addr_d  = w_sp_q;
                mem_wdata_d = pc[15:8];
            end

            ST_PUSH_HI: begin
                mem_req_d = 1'b1;
                if (mem_ack) begin
                    state_d     = ST_PUSH_LO;
                    mem_addr_d  = sp - 16'd1;
                    mem_wdata_d = pc[7:0];
`ifdef INT_IE_PUSH_CANCEL_EN
                    lo_first_d  = 1'b1;
`endif
                end else begin
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = mem_wdata_q;
                end
            end

            ST_PUSH_LO: begin
`ifdef INT_IE_PUSH_CANCEL_EN
                if (lo_first_q) begin
                    idx_d     = enc_idx;
                    idx_vld_d = enc_valid;
                end
`endif
                if (mem_ack) begin
                    state_d  = ST_JUMP;
                    wen_pc_d = 1'b1;
                    if (eff_valid) begin
                        w_pc_d   = vec_addr(eff_idx);
                        if_clr_d = src_onehot(eff_idx);
                    end
                end else begin
                    mem_req_d   = 1'b1;
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = mem_wdata_q;
                end
            end

            ST_JUMP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            ime_clr_q   <= 1'b0;
            if_clr_q    <= '0;
            wen_sp_q    <= 1'b0;
            w_sp_q      <= '0;
            wen_pc_q    <= 1'b0;
            w_pc_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef INT_IE_PUSH_CANCEL_EN
            lo_first_q  <= 1'b0;
            idx_vld_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            ime_clr_q   <= ime_clr_d;
            if_clr_q    <= if_clr_d;
            wen_sp_q    <= wen_sp_d;
            w_sp_q      <= w_sp_d;
            wen_pc_q    <= wen_pc_d;
            w_pc_q      <= w_pc_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef INT_IE_PUSH_CANCEL_EN
            lo_first_q  <= lo_first_d;
            idx_vld_q   <= idx_vld_d;
`endif
        end
    end

endmodule
